// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmit FSM states, frame constants and
// the parity helper used by the host-side blocks.
package ps2_pkg;

    // Host-to-device transmit FSM states
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PARITY,
        STOP,
        ACK,
        RELEASE
    } ps2_tx_state_t;

    // Start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    // Level of an undriven (pulled-up) PS/2 line
    localparam logic PS2_LINE_IDLE = 1'b1;

    // Width of the inhibit and timeout counters
    localparam int PS2_CNT_W = 21;

    // Odd parity bit for a data byte
    function automatic logic oddParity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers for the raw PS/2 CLK and DAT lines plus a
// one-cycle strobe on each falling edge of the synchronised CLK.
// Shared by the host transmitter and the future host receiver.
module ps2_sync_edge
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_o,
    output logic dat_o,
    output logic clk_fall_o
);

    logic [1:0] clkSync_q;
    logic [1:0] datSync_q;
    logic       clkPrev_q;

    // Resample both lines into the clock domain; reset to the idle bus level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkSync_q <= {2{PS2_LINE_IDLE}};
            datSync_q <= {2{PS2_LINE_IDLE}};
            clkPrev_q <= PS2_LINE_IDLE;
        end else begin
            clkSync_q <= {clkSync_q[0], ps2_clk_i};
            datSync_q <= {datSync_q[0], ps2_dat_i};
            clkPrev_q <= clkSync_q[1];
        end
    end

    assign clk_o      = clkSync_q[1];
    assign dat_o      = datSync_q[1];
    assign clk_fall_o = clkPrev_q & ~clkSync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: inhibits the bus, issues a request-to-send, then
// shifts a byte out LSB first on device clock falls, checks the device ACK
// and waits for the bus to go idle. A timeout aborts a stalled transfer.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int INHIBIT_CYCLES = (CLK_HZ / 1000000) * INHIBIT_US;
    localparam int TIMEOUT_CYCLES = (CLK_HZ / 1000) * TIMEOUT_MS;
    localparam logic [PS2_CNT_W-1:0] INHIBIT_LOAD = PS2_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [PS2_CNT_W-1:0] TIMEOUT_LOAD = PS2_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int DATA_BITS = PS2_FRAME_BITS - 3;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    ps2_tx_state_t        state_q;
    logic [7:0]           shift_q;
    logic                 parity_q;
    logic [2:0]           bitIdx_q;
    logic [PS2_CNT_W-1:0] inhCnt_q;
    logic [PS2_CNT_W-1:0] toCnt_q;
    logic                 txReady_q;
    logic                 txDone_q;
    logic                 txErr_q;
    logic                 clkOe_q;
    logic                 datOe_q;

    logic clkSync;
    logic datSync;
    logic clkFall;
    logic inActive;
    logic timeoutHit;

    ps2_sync_edge u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .clk_o      (clkSync),
        .dat_o      (datSync),
        .clk_fall_o (clkFall)
    );

    // The timeout only runs once the device has been asked to clock
    assign inActive   = state_q inside {REQ, DATA, PARITY, STOP, ACK, RELEASE};
    assign timeoutHit = inActive && (toCnt_q == '0);

    // Transmit FSM with registered handshake, status and line drive outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bitIdx_q  <= '0;
            inhCnt_q  <= '0;
            toCnt_q   <= '0;
            txReady_q <= 1'b1;
            txDone_q  <= 1'b0;
            txErr_q   <= 1'b0;
            clkOe_q   <= 1'b0;
            datOe_q   <= 1'b0;
        end else begin
            txDone_q <= 1'b0;
            txErr_q  <= 1'b0;
            if (timeoutHit) begin
                state_q   <= IDLE;
                clkOe_q   <= 1'b0;
                datOe_q   <= 1'b0;
                txErr_q   <= 1'b1;
                txReady_q <= 1'b1;
            end else begin
                if (inActive) begin
                    toCnt_q <= toCnt_q - 1'b1;
                end
                case (state_q)
                    IDLE: begin
                        if (tx_valid && txReady_q) begin
                            shift_q   <= tx_data;
                            parity_q  <= oddParity(tx_data);
                            inhCnt_q  <= INHIBIT_LOAD;
                            clkOe_q   <= 1'b1;
                            txReady_q <= 1'b0;
                            state_q   <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (inhCnt_q == '0) begin
                            clkOe_q <= 1'b0;
                            datOe_q <= 1'b1;
                            toCnt_q <= TIMEOUT_LOAD;
                            state_q <= REQ;
                        end else begin
                            inhCnt_q <= inhCnt_q - 1'b1;
                        end
                    end
                    REQ: begin
                        if (clkFall) begin
                            datOe_q  <= ~shift_q[0];
                            bitIdx_q <= '0;
                            state_q  <= DATA;
                        end
                    end
                    DATA: begin
                        if (clkFall) begin
                            if (bitIdx_q == LAST_BIT) begin
                                datOe_q <= ~parity_q;
                                state_q <= PARITY;
                            end else begin
                                shift_q  <= shift_q >> 1;
                                datOe_q  <= ~shift_q[1];
                                bitIdx_q <= bitIdx_q + 3'd1;
                            end
                        end
                    end
                    PARITY: begin
                        if (clkFall) begin
                            datOe_q <= 1'b0;
                            state_q <= STOP;
                        end
                    end
                    STOP: begin
                        if (clkFall) begin
                            state_q <= ACK;
                        end
                    end
                    ACK: begin
                        if (clkFall) begin
                            if (datSync != PS2_LINE_IDLE) begin
                                state_q <= RELEASE;
                            end else begin
                                txErr_q   <= 1'b1;
                                txReady_q <= 1'b1;
                                state_q   <= IDLE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (clkSync == PS2_LINE_IDLE && datSync == PS2_LINE_IDLE) begin
                            txDone_q  <= 1'b1;
                            txReady_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready   = txReady_q;
    assign tx_done    = txDone_q;
    assign tx_err     = txErr_q;
    assign ps2_clk_oe = clkOe_q;
    assign ps2_dat_oe = datOe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus model with a device BFM that
// clocks frames and decodes the bits, plus a scoreboard monitor that pairs
// every done/err pulse with the expectation queued when the byte was sent.
module tb_ps2_host_tx;

    localparam int CLK_HZ         = 1000000;
    localparam int INHIBIT_US     = 100;
    localparam int TIMEOUT_MS     = 2;
    localparam int INHIBIT_CYCLES = 100;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF_BIT       = 20;

    typedef struct {
        logic [7:0] data;
        logic       parity;
        bit         expDone;
        bit         hasFrame;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       devClkLow = 1'b0;
    logic       devDatLow = 1'b0;
    logic       clkLine;
    logic       datLine;

    int   checks = 0;
    int   errors = 0;
    int   cycleCnt = 0;
    exp_t expQ[$];
    exp_t monEntry;

    logic       rxStart;
    logic [7:0] rxData;
    logic       rxParity;
    logic       rxStop;

    int   pulseCount = 0;
    int   acceptCount = 0;
    int   acceptCycle = -1;
    int   lastDoneCycle = -1;
    int   lastErrCycle = -1;
    int   reqCycle = -1;
    int   inhibitRun = 0;
    int   inhibitLen = 0;
    logic prevClkOe = 1'b0;

    assign clkLine = ~(ps2_clk_oe | devClkLow);
    assign datLine = ~(ps2_dat_oe | devDatLow);

    ps2_host_tx #(
        .CLK_HZ     (CLK_HZ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_i  (clkLine),
        .ps2_dat_i  (datLine),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    // Cycle counter used to timestamp monitor events
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Global guard so a stuck run still ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic failExpired(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=expired required=event", name);
    endtask

    // Scoreboard monitor: handshakes, inhibit length, and pulse checking
    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            acceptCount++;
            acceptCycle = cycleCnt;
        end
        if (prevClkOe && !ps2_clk_oe) reqCycle = cycleCnt;
        if (ps2_clk_oe) inhibitRun++;
        else if (inhibitRun != 0) begin
            inhibitLen = inhibitRun;
            inhibitRun = 0;
        end
        prevClkOe = ps2_clk_oe;
        if (tx_done) lastDoneCycle = cycleCnt;
        if (tx_err) lastErrCycle = cycleCnt;
        if (tx_done || tx_err) begin
            pulseCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_pulse", {30'b0, tx_done, tx_err}, 32'h0);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("outcome_done_err", {30'b0, tx_done, tx_err},
                            {30'b0, monEntry.expDone, ~monEntry.expDone});
                if (monEntry.hasFrame)
                    checkOutput("frame_stop_par_data_start", {21'b0, rxStop, rxParity, rxData, rxStart},
                                {21'b0, 1'b1, monEntry.parity, monEntry.data, 1'b0});
            end
        end
    end

    // Offer a byte and queue the response the monitor should see for it
    task automatic applyStimulus(input logic [7:0] data, input logic parity, input bit expDone,
                                 input bit hasFrame, input bit track);
        int  start;
        bit  ok;
        @(posedge clk); #1;
        tx_data  = data;
        tx_valid = 1'b1;
        if (track) expQ.push_back('{data, parity, expDone, hasFrame});
        start = acceptCount;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); #1;
            if (acceptCount != start) ok = 1'b1;
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
        if (!ok) failExpired("handshake");
    endtask

    // Device BFM: waits for request-to-send, clocks pulses and decodes bits
    task automatic deviceFrame(input int pulses, input bit ackLow);
        bit seen;
        rxStart  = 1'bx;
        rxData   = 8'hxx;
        rxParity = 1'bx;
        rxStop   = 1'bx;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (clkLine && !datLine && !ps2_clk_oe) seen = 1'b1;
        end
        if (!seen) begin
            failExpired("rts_wait");
            return;
        end
        rxStart = datLine;
        repeat (10) @(posedge clk);
        for (int p = 1; p <= pulses; p++) begin
            #1;
            if (p == 11 && ackLow) devDatLow = 1'b1;
            devClkLow = 1'b1;
            repeat (HALF_BIT) @(posedge clk);
            #1;
            if (p <= 8) rxData[p-1] = datLine;
            else if (p == 9) rxParity = datLine;
            else if (p == 10) rxStop = datLine;
            devClkLow = 1'b0;
            repeat (HALF_BIT) @(posedge clk);
        end
        #1;
        devDatLow = 1'b0;
    endtask

    task automatic waitPulse(input int since, input int budget);
        bit seen;
        seen = (pulseCount != since);
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk); #1;
            if (pulseCount != since) seen = 1'b1;
        end
        if (!seen) failExpired("pulse_wait");
    endtask

    task automatic runFrame(input logic [7:0] data, input logic parity);
        int p0;
        applyStimulus(data, parity, 1'b1, 1'b1, 1'b1);
        p0 = pulseCount;
        deviceFrame(12, 1'b1);
        waitPulse(p0, 300);
    endtask

    // Directed test sequence
    initial begin
        int p0;
        int a0;
        int diff;
        int assertCycle;
        bit ok;

        repeat (3) @(posedge clk); #1;
        checkOutput("rst_ready", {31'b0, tx_ready}, 32'd1);
        checkOutput("rst_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
        checkOutput("rst_dat_oe", {31'b0, ps2_dat_oe}, 32'd0);
        checkOutput("rst_done_err", {30'b0, tx_done, tx_err}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;

        p0 = pulseCount;
        for (int i = 0; i < 3; i++) begin
            devClkLow = 1'b1;
            repeat (HALF_BIT) @(posedge clk); #1;
            devClkLow = 1'b0;
            repeat (HALF_BIT) @(posedge clk); #1;
        end
        checkOutput("idle_fall_pulses", pulseCount - p0, 32'd0);
        checkOutput("idle_fall_ready", {31'b0, tx_ready}, 32'd1);
        checkOutput("idle_fall_oe", {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'd0);

        runFrame(8'hF4, 1'b0);
        checkOutput("inhibit_len", inhibitLen, INHIBIT_CYCLES);
        checkOutput("ready_after_done", {31'b0, tx_ready}, 32'd1);
        runFrame(8'h00, 1'b1);
        runFrame(8'hFF, 1'b1);
        runFrame(8'h01, 1'b0);

        $display("[TB] timeout with silent device");
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
        p0 = pulseCount;
        waitPulse(p0, TIMEOUT_CYCLES + 500);
        checkOutput("timeout_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
        checkOutput("timeout_dat_oe", {31'b0, ps2_dat_oe}, 32'd0);
        diff = lastErrCycle - reqCycle;
        checks++;
        if (diff < TIMEOUT_CYCLES - 1 || diff > TIMEOUT_CYCLES + 1) begin
            errors++;
            $display("[TB] FAIL timeout_cycles actual=%0d required=%0d", diff, TIMEOUT_CYCLES);
        end

        $display("[TB] missing device ACK");
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        p0 = pulseCount;
        deviceFrame(12, 1'b0);
        waitPulse(p0, 300);

        $display("[TB] reset during bit 4 of 0xAA");
        applyStimulus(8'hAA, 1'b1, 1'b0, 1'b1, 1'b0);
        deviceFrame(5, 1'b0);
        @(negedge clk); #1;
        checkOutput("mid_bit4_dat_oe", {31'b0, ps2_dat_oe}, 32'd1);
        p0 = pulseCount;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
        checkOutput("mid_rst_dat_oe", {31'b0, ps2_dat_oe}, 32'd0);
        repeat (5) @(posedge clk); #1;
        checkOutput("mid_rst_ready", {31'b0, tx_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (30) @(posedge clk); #1;
        checkOutput("mid_rst_no_pulse", pulseCount - p0, 32'd0);
        runFrame(8'h55, 1'b1);

        $display("[TB] second request held during a transfer");
        applyStimulus(8'hED, 1'b1, 1'b1, 1'b1, 1'b1);
        fork
            deviceFrame(12, 1'b1);
            begin
                repeat (300) @(posedge clk); #1;
                tx_data  = 8'h12;
                tx_valid = 1'b1;
                expQ.push_back('{8'h12, 1'b1, 1'b1, 1'b1});
                a0 = acceptCount;
                assertCycle = cycleCnt;
                ok = 1'b0;
                for (int i = 0; i < 1500 && !ok; i++) begin
                    @(negedge clk); #1;
                    if (acceptCount != a0) ok = 1'b1;
                end
                @(posedge clk); #1;
                tx_valid = 1'b0;
                if (!ok) failExpired("second_handshake");
                else checkOutput("second_accept_after_done",
                                 {31'b0, (acceptCycle >= lastDoneCycle) && (lastDoneCycle > assertCycle)}, 32'd1);
            end
        join
        p0 = pulseCount;
        deviceFrame(12, 1'b1);
        waitPulse(p0, 300);

        repeat (10) @(posedge clk); #1;
        checkOutput("queue_empty", expQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter INHIBIT_US, default 100, duration in microseconds that the host holds PS/2 CLK low before the request-to-send.
REQ-003 Parameter TIMEOUT_MS, default 15, maximum time in milliseconds from leaving INHIBIT to device ACK.
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 tx_data  input  8  byte to send to the device.
REQ-007 tx_valid  input  1  send request; the byte is accepted when tx_valid and tx_ready are both high.
REQ-008 tx_ready  output  1  high only in IDLE.
REQ-009 tx_done  output  1  one-cycle pulse when the device ACK is received and both lines have returned high.
REQ-010 tx_err  output  1  one-cycle pulse on timeout or missing ACK.
REQ-011 ps2_clk_i, ps2_dat_i  input  1 each  raw PS/2 CLK and DAT line levels, asynchronous.
REQ-012 ps2_clk_oe, ps2_dat_oe  output  1 each  open-drain drive enables; 1 = pull the line low, 0 = release it.

Function
REQ-013 ps2_clk_i and ps2_dat_i SHALL pass through 2-FF synchronisers; a falling edge of the synchronised CLK (fall) SHALL be a one-cycle strobe.
REQ-014 The FSM SHALL use the states IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, RELEASE.
REQ-015 IDLE: on handshake, latch tx_data into the shift register, compute odd parity (~^tx_data), load the INHIBIT counter with CLK_HZ/1e6*INHIBIT_US-1 (9999 at the defaults), and go to INHIBIT.
REQ-016 INHIBIT: ps2_clk_oe=1; after the counter reaches 0, set ps2_dat_oe=1 (start bit) and go to REQ; ps2_clk_oe SHALL drop to 0 in the same cycle.
REQ-017 REQ: ps2_dat_oe=1; on the first fall, load the bit index with 0, present bit0, and go to DATA.
REQ-018 DATA: ps2_dat_oe = ~shift[0]; each fall shifts right and increments the index; the fall after bit7 presents parity and goes to PARITY.
REQ-019 Bits SHALL go out LSB first, each changing only in the cycle after a fall.
REQ-020 PARITY: ps2_dat_oe = ~parity; on fall, release DAT (stop bit = 1) and go to STOP.
REQ-021 STOP: on fall, go to ACK.
REQ-022 ACK: on fall, if the synchronised DAT is 0 go to RELEASE, else pulse tx_err and go to IDLE.
REQ-023 RELEASE: when the synchronised CLK and DAT are both 1, pulse tx_done and go to IDLE.
REQ-024 A timeout counter (21 bits, CLK_HZ/1000*TIMEOUT_MS cycles) SHALL run in REQ through RELEASE.
REQ-025 On timeout, both drive enables SHALL be released, tx_err SHALL pulse, and the FSM SHALL go to IDLE; tx_done and tx_err SHALL never pulse together.
REQ-026 tx_valid held high during a transfer SHALL be ignored; the next handshake can occur no earlier than the cycle after tx_done or tx_err.
REQ-027 Any fall in IDLE or INHIBIT (device-initiated traffic) SHALL be ignored; this block never receives.
REQ-028 Drive enables SHALL be registered outputs, glitch-free.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1 after reset, tx_done=0, tx_err=0, counters=0, synchronisers=1 (idle bus).
REQ-030 Reset mid-transfer SHALL release both lines immediately and SHALL produce no done or err pulse.

Structure
REQ-031 A shared package ps2_pkg SHALL hold the state enum ps2_tx_state_t and the constants for the PS/2 frame length (11) and the idle line level (1).
REQ-032 One sub-module, ps2_sync_edge, SHALL hold the 2-FF synchroniser and falling-edge detector, reusable by the future ps2_host_rx.

Verification
REQ-033 Send 0xF4 with a device BFM clocking at 12.5 kHz -> CLK low for 10000 cycles, bits 0,0,1,0,1,1,1,1, parity 0, device ACK, tx_done pulses once, tx_ready returns to 1.
REQ-034 Send 0x00 -> parity bit 1; send 0xFF -> parity bit 1; send 0x01 -> parity bit 0; the BFM decodes all three bytes correctly.
REQ-035 BFM never clocks after REQ -> tx_err pulses at 1500000 cycles +/-1, and both drive enables are 0.
REQ-036 BFM leaves DAT high in the ACK slot -> tx_err pulses and tx_done does not.
REQ-037 rst_n asserted at bit 4 of 0xAA -> both drive enables are 0 the same cycle, no done or err pulse, and the next 0x55 transfer completes.
REQ-038 Second tx_valid asserted mid-transfer -> it is not accepted until after tx_done, then it is sent intact.
